n_clic_timer: RTL and testbench

Memory-less timer peripheral that sits directly upstream of the CLIC in `top_n_clic` and produces the timer interrupt request on CLIC line 0. The core configures it through a CSR write port driven by the CSR stage. The block counts prescaled clock ticks against a compare value and raises a level pending flag. The flag is held until the CLIC acknowledges that it has taken the interrupt.

---
 rtl/n_clic_timer.sv | 127 ++++++++++++
 tb/tb_n_clic_timer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/n_clic_timer.sv
// rtl/n_clic_timer.sv - prescaled compare timer that drives CLIC line 0
// N_CLIC_TIMER_ONESHOT_EN enables the oneshot bit (cfg[30]); without it the timer is always periodic.
module n_clic_timer #(
  parameter int unsigned TimerWidth     = 16,
  parameter int unsigned PrescalerWidth = 4,
  parameter logic [11:0] CsrAddr        = 12'h400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        int_pend,
  input  logic        int_ack
);

  localparam int unsigned PcntWidth = 1 << PrescalerWidth;
  localparam logic [11:0] CntAddr   = CsrAddr + 12'd1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e                    state_q, state_d;
  logic [TimerWidth-1:0]     cmp_q, cnt_q, cnt_d;
  logic [PrescalerWidth-1:0] pre_q;
  logic [PcntWidth-1:0]      pcnt_q, pcnt_d, pmask;
  logic                      pend_q, pend_d;
  logic                      cfg_we, en, tick, match, oneshot;
  logic [31:0]               cfg_rd;
  logic                      unused_wdata;

  assign cfg_we       = csr_we && (csr_addr == CsrAddr);
  assign en           = (state_q == RUN);
  // Low pre bits of pcnt all ones marks the last clock of a 2^pre period.
  assign pmask        = ~({PcntWidth{1'b1}} << pre_q);
  assign tick         = en && ((pcnt_q & pmask) == pmask);
  assign match        = (cnt_q == cmp_q);
  assign int_pend     = pend_q;
  assign unused_wdata = ^csr_wdata;

`ifdef N_CLIC_TIMER_ONESHOT_EN
  logic oneshot_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oneshot_q <= 1'b0;
    end else if (cfg_we) begin
      oneshot_q <= csr_wdata[30];
    end
  end
  assign oneshot = oneshot_q;
`else
  assign oneshot = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (cfg_we) begin
      state_d = csr_wdata[31] ? RUN : IDLE;
    end else if (tick && match && oneshot) begin
      state_d = IDLE;
    end
  end

  // A config write restarts counting and swallows any tick in the same cycle.
  always_comb begin
    cnt_d  = cnt_q;
    pcnt_d = pcnt_q;
    pend_d = pend_q;
    if (int_ack) begin
      pend_d = 1'b0;
    end
    if (cfg_we) begin
      cnt_d  = '0;
      pcnt_d = '0;
      if (!csr_wdata[31]) begin
        pend_d = 1'b0;
      end
    end else begin
      if (en) begin
        pcnt_d = pcnt_q + PcntWidth'(1);
      end
      if (tick) begin
        if (match) begin
          cnt_d  = '0;
          pend_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TimerWidth'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cmp_q   <= '0;
      pre_q   <= '0;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      pend_q  <= pend_d;
      if (cfg_we) begin
        cmp_q <= csr_wdata[TimerWidth-1:0];
        pre_q <= csr_wdata[16 +: PrescalerWidth];
      end
    end
  end

  always_comb begin
    cfg_rd                        = '0;
    cfg_rd[TimerWidth-1:0]        = cmp_q;
    cfg_rd[16 +: PrescalerWidth]  = pre_q;
    cfg_rd[30]                    = oneshot;
    cfg_rd[31]                    = en;
    csr_rdata                     = '0;
    if (csr_addr == CsrAddr) begin
      csr_rdata = cfg_rd;
    end else if (csr_addr == CntAddr) begin
      csr_rdata = 32'(cnt_q);
    end
  end

endmodule

// File: tb/tb_n_clic_timer.sv
// tb/tb_n_clic_timer.sv - directed self-checking bench for n_clic_timer
module tb_n_clic_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        int_pend;
  logic        int_ack;

  int passed = 0;
  int total  = 0;

  n_clic_timer dut (
    .clk       (clk),
    .reset     (reset),
    .csr_we    (csr_we),
    .csr_addr  (csr_addr),
    .csr_wdata (csr_wdata),
    .csr_rdata (csr_rdata),
    .int_pend  (int_pend),
    .int_ack   (int_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_at(input logic [11:0] a, input logic [31:0] d);
    csr_we    = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    tick();
    csr_we    = 1'b0;
    csr_wdata = '0;
  endtask

  task automatic wr(input logic [31:0] d);
    wr_at(12'h400, d);
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    csr_addr = a;
    #1;
    d = csr_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0;
    repeat (2) tick();
    total++; if (int_pend !== 1'b0) $display("FAIL reset_pend: got %b expected 0", int_pend); else passed++;
    rd(12'h400, d);
    total++; if (d !== 32'h0) $display("FAIL reset_cfg: got %h expected 00000000", d); else passed++;
    rd(12'h401, d);
    total++; if (d !== 32'h0) $display("FAIL reset_cnt: got %h expected 00000000", d); else passed++;
    reset = 1'b1;
    repeat (5) tick();
    total++; if (int_pend !== 1'b0) $display("FAIL idle_after_reset: got %b expected 0", int_pend); else passed++;
  endtask

  task automatic test_periodic();
    logic [31:0] d;
    wr(32'h8000_0003);
    rd(12'h400, d);
    total++; if (d !== 32'h8000_0003) $display("FAIL cfg_readback: got %h expected 80000003", d); else passed++;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) tick();
      rd(12'h401, d);
      total++; if (d !== 32'(k % 4)) $display("FAIL periodic_cnt[%0d]: got %0d expected %0d", k, d, k % 4); else passed++;
      total++; if (int_pend !== (k >= 4)) $display("FAIL periodic_pend[%0d]: got %b expected %b", k, int_pend, k >= 4); else passed++;
    end
  endtask

  task automatic test_ack_periodic();
    logic e;
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    total++; if (int_pend !== 1'b0) $display("FAIL ack_clears: got %b expected 0", int_pend); else passed++;
    wr(32'h8000_0003);
    for (int k = 1; k <= 13; k++) begin
      tick();
      e = (k % 4 == 0);
      total++; if (int_pend !== e) $display("FAIL ack_periodic_pend[%0d]: got %b expected %b", k, int_pend, e); else passed++;
      int_ack = e;
    end
    int_ack = 1'b0;
  endtask

  task automatic test_prescale();
    logic [31:0] d;
    logic        e;
    wr(32'h8002_0001);
    rd(12'h400, d);
    total++; if (d !== 32'h8002_0001) $display("FAIL pre_cfg: got %h expected 80020001", d); else passed++;
    for (int k = 1; k <= 16; k++) begin
      tick();
      e = (k == 8) || (k == 16);
      total++; if (int_pend !== e) $display("FAIL pre_pend[%0d]: got %b expected %b", k, int_pend, e); else passed++;
      int_ack = (k == 8) || (k == 15);
    end
    int_ack = 1'b0;
  endtask

  task automatic test_write_clears();
    logic [31:0] d;
    total++; if (int_pend !== 1'b1) $display("FAIL wc_pre_pend: got %b expected 1", int_pend); else passed++;
    wr(32'h0000_0005);
    total++; if (int_pend !== 1'b0) $display("FAIL wc_pend: got %b expected 0", int_pend); else passed++;
    wr_at(12'h401, 32'h8000_0001);
    repeat (10) tick();
    rd(12'h401, d);
    total++; if (d !== 32'h0) $display("FAIL wc_cnt_held: got %h expected 00000000", d); else passed++;
    total++; if (int_pend !== 1'b0) $display("FAIL wc_pend_held: got %b expected 0", int_pend); else passed++;
    rd(12'h400, d);
    total++; if (d !== 32'h0000_0005) $display("FAIL wc_cfg: got %h expected 00000005", d); else passed++;
    rd(12'h402, d);
    total++; if (d !== 32'h0) $display("FAIL other_addr: got %h expected 00000000", d); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    wr(32'h8000_0003);
    repeat (3) tick();
    rd(12'h401, d);
    total++; if (d !== 32'd3) $display("FAIL b2b_cnt_before: got %0d expected 3", d); else passed++;
    wr(32'h8000_0003);
    rd(12'h401, d);
    total++; if (d !== 32'd0) $display("FAIL b2b_cnt_after: got %0d expected 0", d); else passed++;
    total++; if (int_pend !== 1'b0) $display("FAIL b2b_tick_dropped: got %b expected 0", int_pend); else passed++;
    repeat (3) tick();
    total++; if (int_pend !== 1'b0) $display("FAIL b2b_early: got %b expected 0", int_pend); else passed++;
    tick();
    total++; if (int_pend !== 1'b1) $display("FAIL b2b_rise: got %b expected 1", int_pend); else passed++;
    int_ack = 1'b1;
    wr(32'h0000_0000);
    int_ack = 1'b0;
    total++; if (int_pend !== 1'b0) $display("FAIL dis_and_ack: got %b expected 0", int_pend); else passed++;
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    logic        e;
    wr(32'hC000_0002);
`ifdef N_CLIC_TIMER_ONESHOT_EN
    for (int k = 1; k <= 3; k++) begin
      tick();
      e = (k == 3);
      total++; if (int_pend !== e) $display("FAIL os_pend[%0d]: got %b expected %b", k, int_pend, e); else passed++;
    end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    e = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      e = e | int_pend;
    end
    total++; if (e !== 1'b0) $display("FAIL os_no_rerise: got %b expected 0", e); else passed++;
    rd(12'h400, d);
    total++; if (d !== 32'h4000_0002) $display("FAIL os_cfg: got %h expected 40000002", d); else passed++;
`else
    rd(12'h400, d);
    total++; if (d !== 32'h8000_0002) $display("FAIL os_cfg: got %h expected 80000002", d); else passed++;
    for (int k = 1; k <= 6; k++) begin
      tick();
      e = (k == 3) || (k == 6);
      total++; if (int_pend !== e) $display("FAIL os_periodic_pend[%0d]: got %b expected %b", k, int_pend, e); else passed++;
      int_ack = e;
    end
    int_ack = 1'b0;
`endif
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    wr(32'h8000_0003);
    repeat (5) tick();
    total++; if (int_pend !== 1'b1) $display("FAIL ar_pre_pend: got %b expected 1", int_pend); else passed++;
    #2;
    reset = 1'b0;
    #1;
    total++; if (int_pend !== 1'b0) $display("FAIL ar_pend: got %b expected 0", int_pend); else passed++;
    rd(12'h400, d);
    total++; if (d !== 32'h0) $display("FAIL ar_cfg: got %h expected 00000000", d); else passed++;
    rd(12'h401, d);
    total++; if (d !== 32'h0) $display("FAIL ar_cnt: got %h expected 00000000", d); else passed++;
    tick();
    reset = 1'b1;
    repeat (20) tick();
    rd(12'h401, d);
    total++; if (d !== 32'h0) $display("FAIL ar_cnt_idle: got %h expected 00000000", d); else passed++;
    total++; if (int_pend !== 1'b0) $display("FAIL ar_no_irq: got %b expected 0", int_pend); else passed++;
  endtask

  initial begin
    reset     = 1'b0;
    csr_we    = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;
    int_ack   = 1'b0;
    test_reset();
    test_periodic();
    test_ack_periodic();
    test_prescale();
    test_write_clears();
    test_back_to_back();
    test_oneshot();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
